fp_add_sub_scheduler: RTL and testbench
=======================================

# fp_add_sub_scheduler

Round-robin scheduler that shares a single combinational `fp_add_sub` datapath between `N_REQ` independent requesters. Each cycle it grants at most one pending request, drives the datapath, and captures the result, flags and requester ID into a one-entry output register with a valid/ready handshake. The block sits between several issuing units, such as the FPU decode lanes, and the shared adder/subtractor. It is the only path by which those units reach the adder.

## Interface
Parameters:
- `N_REQ`, default 4: number of requesters, 2..16.
- `ID_W`, localparam `$clog2(N_REQ)`: requester ID width.

Ports (one clock; reset is asynchronous and active-high):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  N_REQ  request pending, one bit per requester.
- `req_ready`  out  N_REQ  request accepted this cycle; one-hot or zero.
- `req_opd1`  in  N_REQ*32  operand 1 per requester; slice i = `[32*i+31:32*i]`.
- `req_opd2`  in  N_REQ*32  operand 2 per requester, same slicing.
- `req_op`  in  N_REQ  0 = add, 1 = subtract.
- `rsp_valid`  out  1  output register holds a result.
- `rsp_ready`  in  1  consumer accepts the result.
- `rsp_id`  out  ID_W  index of the requester that produced the result.
- `rsp_res`  out  32  IEEE-754 single-precision result.
- `rsp_flags`  out  4  `{exp_overflow, exp_underflow, nan, zero}`.

## Operation
- State:
  - output-register FSM with states EMPTY and FULL;
  - priority pointer `ptr`, width ID_W;
  - output payload register.
- `can_issue` = (state == EMPTY) || rsp_ready.
- Grant:
  - The first asserted `req_valid[i]` scanning from `ptr` upward, wrapping N_REQ-1 -> 0.
  - The grant is combinational and valid only when `|req_valid`.
- Issue: `can_issue && |req_valid`. Only then `req_ready[grant] = 1`; all other `req_ready` bits are 0.
- On issue:
  - The datapath sees the granted slice's `opd1`, `opd2` and `op`.
  - The output register loads `res`, the four flags and `grant`.
  - State becomes FULL.
  - `ptr <= (grant == N_REQ-1) ? 0 : grant+1`.
- FSM transitions:
  - EMPTY -> FULL on issue.
  - FULL -> EMPTY on `rsp_ready` with no issue.
  - FULL -> FULL on `rsp_ready` with issue (back-to-back), or on `!rsp_ready`.
- FULL && !rsp_ready:
  - `req_ready` is all zero.
  - The payload is held stable and `ptr` does not change.
- Requesters hold payload and `req_valid` until `req_ready`. The grant may move to another requester between cycles while nothing issues; this is legal.
- A single active requester wins regardless of `ptr`.
- Datapath results, including NaN, overflow and zero encodings, are passed through unmodified.
- `req_ready` is forced to 0 while `rst` is high.

## Timing
- Reset values:
  - `rsp_valid = 0`
  - `rsp_id = 0`
  - `rsp_res = 0x00000000`
  - `rsp_flags = 0`
  - `ptr = 0`
  - state EMPTY
- Latency: request accepted at edge k -> `rsp_valid = 1` with the result immediately after edge k.
- Throughput: 1 result/cycle when `rsp_ready` is held high.
- Fairness: with all requesters continuously valid, grants follow 0,1,...,N_REQ-1,0,...; no requester waits more than N_REQ-1 issues.
- Reset mid-operation:
  - Any held result is discarded and `ptr` returns to 0.
  - Requests are not accepted until `rst` deasserts. The first grant goes to the lowest valid index.
- Combinational paths: `req_valid`/`rsp_ready` -> `req_ready`. The critical path runs grant mux -> `fp_add_sub` -> output register.

## Structure
- Package `fp_pkg`:
  - typedef `fp_flags_t` (packed struct: ovf, undf, nan, zero);
  - localparams `FP_ADD = 1'b0` and `FP_SUB = 1'b1`;
  - state enum `sched_state_e` {EMPTY, FULL}.
- Sub-module `rr_arbiter #(N)`:
  - inputs `req`, `ptr`;
  - outputs one-hot `gnt`, binary `gnt_idx`, `any`.
- One `fp_add_sub` instance; its operand inputs come from the one-hot grant mux.
- Target size is about 150-250 lines including the arbiter.

## Test plan
- Single op:
  - Stimulus: requester 2, 0x3F800000 + 0x40000000, op=0.
  - Response: next cycle `rsp_valid=1`, `rsp_id=2`, `rsp_res=0x40400000`, flags=0.
- Round-robin:
  - Stimulus: all 4 requesters valid continuously, `rsp_ready=1`.
  - Response: `rsp_id` sequence 0,1,2,3,0; one `req_ready` per cycle.
- Backpressure:
  - Stimulus: FULL with `rsp_ready=0` for 5 cycles, requesters 1 and 3 valid.
  - Response: `req_ready=0`, `rsp_*` stable. When `rsp_ready` rises, requester 1 issues the same cycle (back-to-back).
- Exceptions:
  - 0x7FC00000 + 0x3F800000 -> `rsp_res=0x7F800001`, nan flag set.
  - 0x7F7FFFFF + 0x7F7FFFFF -> `rsp_res=0x7F800000`, overflow flag set.
  - 0x3F800000 - 0x3F800000 -> `rsp_res=0x00000000`, zero flag set.
- Wrap/isolation:
  - Stimulus: `ptr=3`, only requester 0 valid.
  - Response: requester 0 is granted and `ptr` becomes 1.
- Reset mid-flight:
  - Stimulus: assert `rst` while FULL, asynchronously between edges.
  - Response: `rsp_valid` drops immediately and all outputs take their reset values. After release, the grant goes to the lowest valid index.

Source files
------------

// File: rtl/fp_pkg.sv
// Shared types and constants for the single-precision add/subtract scheduler.
package fp_pkg;

    // Result status flags, MSB first: exp_overflow, exp_underflow, nan, zero.
    typedef struct packed {
        logic ovf;
        logic undf;
        logic nan;
        logic zero;
    } fp_flags_t;

    localparam logic FP_ADD = 1'b0;
    localparam logic FP_SUB = 1'b1;

    // Canonical NaN produced for every invalid or NaN-input operation.
    localparam logic [31:0] FP_QNAN = 32'h7F80_0001;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } sched_state_e;

endpackage

// File: rtl/fp_add_sub.sv
// Combinational IEEE-754 single-precision add/subtract.
// Subnormal inputs are flushed to zero, results are truncated, exponent
// overflow saturates to infinity and underflow flushes to signed zero.
module fp_add_sub
    import fp_pkg::*;
(
    input  logic [31:0] opd1,
    input  logic [31:0] opd2,
    input  logic        op,
    output logic [31:0] res,
    output fp_flags_t   flags
);

    logic              sa, sb_eff;
    logic [7:0]        ea, eb;
    logic [22:0]       fa, fb;
    logic [23:0]       ma, mb;
    logic              a_nan, b_nan, a_inf, b_inf;
    logic              swap, eff_sub;
    logic [7:0]        e_big, e_sml, e_diff;
    logic [23:0]       m_big, m_sml;
    logic              s_big, s_sml;
    logic [26:0]       mx_big, mx_sml;
    logic [27:0]       sum;
    logic [4:0]        lz;
    logic [26:0]       norm;
    logic signed [9:0] exp_n;
    logic [22:0]       frac_n;
    logic [35:0]       packed_out;

    // Leading-zero count of the 27-bit magnitude (27 when all zero).
    function automatic logic [4:0] lzc27(input logic [26:0] v);
        logic [4:0] n;
        logic       hit;
        n   = 5'd27;
        hit = 1'b0;
        for (int i = 26; i >= 0; i--) begin
            if (!hit && v[i]) begin
                n   = 5'(26 - i);
                hit = 1'b1;
            end
        end
        return n;
    endfunction

    // Exponent saturation/flush and final packing: {flags, result}.
    function automatic logic [35:0] sat_pack(input logic sign,
                                             input logic signed [9:0] e,
                                             input logic [22:0] f);
        if (e >= 10'sd255) begin
            return {4'b1000, sign, 8'hFF, 23'd0};
        end
        if (e <= 10'sd0) begin
            return {4'b0101, sign, 31'd0};
        end
        return {4'b0000, sign, e[7:0], f};
    endfunction

    assign sa     = opd1[31];
    assign ea     = opd1[30:23];
    assign fa     = opd1[22:0];
    assign sb_eff = opd2[31] ^ (op == FP_SUB);
    assign eb     = opd2[30:23];
    assign fb     = opd2[22:0];

    assign a_nan = (ea == 8'hFF) && (fa != 23'd0);
    assign b_nan = (eb == 8'hFF) && (fb != 23'd0);
    assign a_inf = (ea == 8'hFF) && (fa == 23'd0);
    assign b_inf = (eb == 8'hFF) && (fb == 23'd0);

    // Subnormals carry no hidden bit and are treated as zero.
    assign ma = (ea == 8'd0) ? 24'd0 : {1'b1, fa};
    assign mb = (eb == 8'd0) ? 24'd0 : {1'b1, fb};

    // Order operands by magnitude so the subtraction never goes negative.
    assign swap  = {eb, fb} > {ea, fa};
    assign e_big = swap ? eb : ea;
    assign e_sml = swap ? ea : eb;
    assign m_big = swap ? mb : ma;
    assign m_sml = swap ? ma : mb;
    assign s_big = swap ? sb_eff : sa;
    assign s_sml = swap ? sa : sb_eff;

    assign eff_sub = s_big ^ s_sml;
    assign e_diff  = e_big - e_sml;
    assign mx_big  = {m_big, 3'b000};
    assign mx_sml  = (e_diff > 8'd26) ? 27'd0 : ({m_sml, 3'b000} >> e_diff);
    assign sum     = eff_sub ? ({1'b0, mx_big} - {1'b0, mx_sml})
                             : ({1'b0, mx_big} + {1'b0, mx_sml});

    // Normalise, then resolve special operands ahead of the finite result.
    always_comb begin
        lz     = lzc27(sum[26:0]);
        norm   = sum[26:0] << lz;
        exp_n  = $signed({2'b00, e_big});
        frac_n = 23'(norm >> 3);
        if (sum[27]) begin
            exp_n  = $signed({2'b00, e_big}) + 10'sd1;
            frac_n = sum[26:4];
        end else begin
            exp_n  = $signed({2'b00, e_big}) - $signed({5'd0, lz});
        end

        packed_out = sat_pack(s_big, exp_n, frac_n);
        if (a_nan || b_nan || (a_inf && b_inf && eff_sub)) begin
            packed_out = {4'b0010, FP_QNAN};
        end else if (a_inf || b_inf) begin
            packed_out = {4'b0000, (a_inf ? sa : sb_eff), 8'hFF, 23'd0};
        end else if (sum == 28'd0) begin
            packed_out = {4'b0001, 32'd0};
        end
    end

    assign res   = packed_out[31:0];
    assign flags = fp_flags_t'(packed_out[35:32]);

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first asserted request scanning upward from ptr, wrapping.
module rr_arbiter #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          any
);

    logic found;

    // Index of the k-th candidate after ptr, wrapping N-1 -> 0.
    function automatic logic [IW-1:0] wrap_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // Priority scan starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        any     = |req;
        for (int k = 0; k < N; k++) begin
            if (!found && req[wrap_idx(ptr, k)]) begin
                found                 = 1'b1;
                gnt[wrap_idx(ptr, k)] = 1'b1;
                gnt_idx               = wrap_idx(ptr, k);
            end
        end
    end

endmodule

// File: rtl/fp_add_sub_scheduler.sv
// Round-robin sharing of one fp_add_sub datapath among N_REQ requesters,
// with a one-entry valid/ready output register.
module fp_add_sub_scheduler
    import fp_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    output logic [N_REQ-1:0]    req_ready,
    input  logic [N_REQ*32-1:0] req_opd1,
    input  logic [N_REQ*32-1:0] req_opd2,
    input  logic [N_REQ-1:0]    req_op,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [ID_W-1:0]     rsp_id,
    output logic [31:0]         rsp_res,
    output logic [3:0]          rsp_flags
);

    sched_state_e     state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_idx;
    logic             any_req;
    logic             can_issue;
    logic             issue;

    logic [31:0]      mux_opd1, mux_opd2;
    logic             mux_op;
    logic [31:0]      dp_res;
    fp_flags_t        dp_flags;

    logic [ID_W-1:0]  id_p0;
    logic [31:0]      res_p0;
    logic [3:0]       flags_p0;

    rr_arbiter #(
        .N (N_REQ)
    ) u_arb (
        .req     (req_valid),
        .ptr     (ptr_q),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any_req)
    );

    // One-hot AND-OR mux of the granted requester's operands.
    always_comb begin
        mux_opd1 = '0;
        mux_opd2 = '0;
        mux_op   = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            mux_opd1 = mux_opd1 | (req_opd1[32*i +: 32] & {32{gnt[i]}});
            mux_opd2 = mux_opd2 | (req_opd2[32*i +: 32] & {32{gnt[i]}});
            mux_op   = mux_op   | (req_op[i] & gnt[i]);
        end
    end

    fp_add_sub u_dp (
        .opd1  (mux_opd1),
        .opd2  (mux_opd2),
        .op    (mux_op),
        .res   (dp_res),
        .flags (dp_flags)
    );

    // Issue decision, handshake outputs, next state and next pointer.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        req_ready = '0;
        can_issue = (state_q == EMPTY) || rsp_ready;
        issue     = can_issue && any_req && !rst;
        if (issue) begin
            req_ready = gnt;
            state_d   = FULL;
            ptr_d     = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
        end else if ((state_q == FULL) && rsp_ready) begin
            state_d = EMPTY;
        end
    end

    // Control state: FSM and priority pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    // Stage p0: output payload register, loaded only on issue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            id_p0    <= '0;
            res_p0   <= '0;
            flags_p0 <= '0;
        end else if (issue) begin
            id_p0    <= gnt_idx;
            res_p0   <= dp_res;
            flags_p0 <= dp_flags;
        end
    end

    assign rsp_valid = (state_q == FULL);
    assign rsp_id    = id_p0;
    assign rsp_res   = res_p0;
    assign rsp_flags = flags_p0;

endmodule

// File: tb/tb_fp_add_sub_scheduler.sv
// Directed bench for fp_add_sub_scheduler with hand-computed expected values.
module tb_fp_add_sub_scheduler;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*32-1:0] req_opd1;
    logic [N*32-1:0] req_opd2;
    logic [N-1:0]    req_op;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [1:0]      rsp_id;
    logic [31:0]     rsp_res;
    logic [3:0]      rsp_flags;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] rr_exp [4];

    fp_add_sub_scheduler #(
        .N_REQ (N)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opd1  (req_opd1),
        .req_opd2  (req_opd2),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_res   (rsp_res),
        .rsp_flags (rsp_flags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic o);
        req_opd1[32*i +: 32] = a;
        req_opd2[32*i +: 32] = b;
        req_op[i]            = o;
    endtask

    // From a falling edge, advance through one rising edge to the next falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Single-requester transaction; called at a falling edge with issue possible.
    task automatic run_op(input string tag, input int i, input logic [31:0] a,
                          input logic [31:0] b, input logic o,
                          input logic [31:0] er, input logic [3:0] ef);
        set_req(i, a, b, o);
        req_valid = 4'(1 << i);
        #1;
        chk({tag, "_rdy"}, 32'(req_ready), 32'(1 << i));
        step();
        chk({tag, "_vld"}, 32'(rsp_valid), 32'd1);
        chk({tag, "_id"}, 32'(rsp_id), 32'(i));
        chk({tag, "_res"}, rsp_res, er);
        chk({tag, "_flags"}, 32'(ef), 32'(rsp_flags) ^ 32'(ef) ^ 32'(ef));
        req_valid = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rr_exp[0] = 32'h4000_0000;
        rr_exp[1] = 32'h4040_0000;
        rr_exp[2] = 32'h4080_0000;
        rr_exp[3] = 32'h40A0_0000;

        rst       = 1'b1;
        req_valid = '0;
        req_op    = '0;
        req_opd1  = '0;
        req_opd2  = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending while rst is high.
        @(negedge clk);
        req_valid = 4'b1111;
        #1;
        chk("rst_vld", 32'(rsp_valid), 32'd0);
        chk("rst_id", 32'(rsp_id), 32'd0);
        chk("rst_res", rsp_res, 32'd0);
        chk("rst_flags", 32'(rsp_flags), 32'd0);
        chk("rst_rdy", 32'(req_ready), 32'd0);
        req_valid = '0;
        @(negedge clk);
        rst = 1'b0;

        // Single op: 1.0 + 2.0 from requester 2; ptr moves to 3.
        run_op("single", 2, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000);
        rsp_ready = 1'b1;
        step();
        chk("drain_vld", 32'(rsp_valid), 32'd0);

        // Wrap/isolation: ptr=3, only requester 0 valid; ptr must become 1.
        run_op("wrap", 0, 32'h3F80_0000, 32'h3F80_0000, 1'b0, 32'h4000_0000, 4'b0000);
        set_req(1, 32'h4000_0000, 32'h3F80_0000, 1'b1);
        req_valid = 4'b0011;
        #1;
        chk("wrap_ptr_rdy", 32'(req_ready), 32'b0010);
        step();
        chk("wrap_ptr_id", 32'(rsp_id), 32'd1);
        chk("wrap_ptr_res", rsp_res, 32'h3F80_0000);
        req_valid = '0;

        // Round-robin from a fresh reset: 0,1,2,3,0 at one result per cycle.
        rst = 1'b1;
        #1;
        chk("rst2_vld", 32'(rsp_valid), 32'd0);
        chk("rst2_res", rsp_res, 32'd0);
        step();
        rst = 1'b0;
        set_req(0, 32'h3F80_0000, 32'h3F80_0000, 1'b0);
        set_req(1, 32'h4000_0000, 32'h3F80_0000, 1'b0);
        set_req(2, 32'h4040_0000, 32'h3F80_0000, 1'b0);
        set_req(3, 32'h4080_0000, 32'h3F80_0000, 1'b0);
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("rr_rdy", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            chk("rr_vld", 32'(rsp_valid), 32'd1);
            chk("rr_id", 32'(rsp_id), 32'(k % 4));
            chk("rr_res", rsp_res, rr_exp[k % 4]);
        end

        // Backpressure: held result (id 0, 2.0) stays put, no request accepted.
        rsp_ready = 1'b0;
        req_valid = 4'b1010;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_rdy", 32'(req_ready), 32'd0);
            chk("bp_vld", 32'(rsp_valid), 32'd1);
            chk("bp_id", 32'(rsp_id), 32'd0);
            chk("bp_res", rsp_res, 32'h4000_0000);
            step();
        end
        rsp_ready = 1'b1;
        #1;
        chk("bp_b2b_rdy", 32'(req_ready), 32'b0010);
        step();
        chk("bp_b2b_vld", 32'(rsp_valid), 32'd1);
        chk("bp_b2b_id", 32'(rsp_id), 32'd1);
        chk("bp_b2b_res", rsp_res, 32'h4040_0000);
        req_valid = '0;
        step();
        chk("bp_drain_vld", 32'(rsp_valid), 32'd0);

        // Exceptional encodings pass through with their flags.
        run_op("nan", 1, 32'h7FC0_0000, 32'h3F80_0000, 1'b0, 32'h7F80_0001, 4'b0010);
        run_op("ovf", 1, 32'h7F7F_FFFF, 32'h7F7F_FFFF, 1'b0, 32'h7F80_0000, 4'b1000);
        run_op("zero", 1, 32'h3F80_0000, 32'h3F80_0000, 1'b1, 32'h0000_0000, 4'b0001);

        // Reset mid-flight, asserted between clock edges while FULL.
        run_op("pre_rst", 1, 32'h3F80_0000, 32'h4000_0000, 1'b0, 32'h4040_0000, 4'b0000);
        rsp_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_vld", 32'(rsp_valid), 32'd0);
        chk("mid_rst_id", 32'(rsp_id), 32'd0);
        chk("mid_rst_res", rsp_res, 32'd0);
        chk("mid_rst_flags", 32'(rsp_flags), 32'd0);
        req_valid = 4'b1100;
        #1;
        chk("mid_rst_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_rdy", 32'(req_ready), 32'b0100);
        step();
        chk("post_rst_vld", 32'(rsp_valid), 32'd1);
        chk("post_rst_id", 32'(rsp_id), 32'd2);
        chk("post_rst_res", rsp_res, 32'h4080_0000);
        req_valid = '0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
